// File: rtl/i2c_bitrecv.sv
// I2C target-side bit receiver: filters SCL/SDA, decodes START/STOP/bits,
// and drives SDA open-drain with a hold time after each SCL fall.
module i2c_bitrecv #(
  parameter int FILTER_CYCLES = 4,
  parameter int HOLD_CYCLES   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       event_valid,
  output logic [2:0] event_code,
  output logic       bus_busy,
  input  logic       drive_en,
  input  logic       drive_bit,
  output logic       drive_miss
);

  localparam logic [2:0]  EV_START  = 3'd1;
  localparam logic [2:0]  EV_STOP   = 3'd2;
  localparam logic [2:0]  EV_BIT0   = 3'd3;
  localparam logic [2:0]  EV_BIT1   = 3'd4;
  localparam logic [3:0]  FLT_LAST  = 4'(FILTER_CYCLES - 1);
  localparam logic [11:0] HOLD_LOAD = 12'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAITLOW,
    LOW,
    HIGH
  } state_t;

  state_t      state;
  logic [1:0]  scl_sy;
  logic [1:0]  sda_sy;
  logic        scl_f;
  logic        sda_f;
  logic        scl_d;
  logic        sda_d;
  logic [3:0]  scl_cnt;
  logic [3:0]  sda_cnt;
  logic [11:0] hold_cnt;
  logic        oe;
  logic        bit_q;

  logic scl_rise;
  logic scl_fall;
  logic scl_edge;
  logic start_c;
  logic stop_c;

  assign sda = oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sy  <= 2'b11;
      sda_sy  <= 2'b11;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_sy <= {scl_sy[0], scl};
      sda_sy <= {sda_sy[0], sda};
      scl_d  <= scl_f;
      sda_d  <= sda_f;
      if (scl_sy[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FLT_LAST) begin
        scl_f   <= ~scl_f;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_sy[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FLT_LAST) begin
        sda_f   <= ~sda_f;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
    end
  end

  // A simultaneous SCL edge masks any SDA condition.
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign scl_edge = scl_f ^ scl_d;
  assign start_c  = ~scl_edge & scl_f & ~sda_f & sda_d;
  assign stop_c   = ~scl_edge & scl_f & sda_f & ~sda_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      event_valid <= 1'b0;
      event_code  <= 3'd0;
      bus_busy    <= 1'b0;
      drive_miss  <= 1'b0;
      hold_cnt    <= '0;
      oe          <= 1'b0;
      bit_q       <= 1'b0;
    end else begin
      event_valid <= 1'b0;
      event_code  <= 3'd0;
      drive_miss  <= 1'b0;
      if (start_c) begin
        state       <= WAITLOW;
        bus_busy    <= 1'b1;
        event_valid <= 1'b1;
        event_code  <= EV_START;
        oe          <= 1'b0;
        hold_cnt    <= '0;
      end else if (stop_c) begin
        state       <= IDLE;
        bus_busy    <= 1'b0;
        event_valid <= 1'b1;
        event_code  <= EV_STOP;
        oe          <= 1'b0;
        hold_cnt    <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          WAITLOW: if (scl_fall) state <= LOW;
          LOW: begin
            if (scl_rise) begin
              state <= HIGH;
              bit_q <= sda_f;
            end
          end
          HIGH: begin
            if (scl_fall) begin
              state       <= LOW;
              event_valid <= 1'b1;
              event_code  <= bit_q ? EV_BIT1 : EV_BIT0;
            end
          end
          default: state <= IDLE;
        endcase
        // Drive updates land only while SCL is low; a rise abandons them.
        if (scl_fall && (state == WAITLOW || state == HIGH)) begin
          hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != 12'd0) begin
          if (scl_f) begin
            hold_cnt   <= '0;
            drive_miss <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 12'd1;
            if (hold_cnt == 12'd1) oe <= drive_en & ~drive_bit;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_bitrecv.sv
// Bench for i2c_bitrecv: a bus master drives SCL/SDA, a transaction-level
// model predicts events and their pin-to-strobe latency.
module tb_i2c_bitrecv;

  localparam int F   = 4;
  localparam int H   = 100;
  localparam int LAT = F + 3;
  localparam int EV_START = 1;
  localparam int EV_STOP  = 2;
  localparam int EV_BIT0  = 3;
  localparam int EV_BIT1  = 4;

  typedef struct {
    logic [7:0] data;
    int         nbits;
    logic       ninth;
    logic [8:0] exp_bits;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_low = 1'b0;
  logic       drive_en = 1'b0;
  logic       drive_bit = 1'b0;
  wire        sda;
  logic       event_valid;
  logic [2:0] event_code;
  logic       bus_busy;
  logic       drive_miss;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_rise = 0;
  int miss_n = 0;
  int miss_cyc = 0;
  int consec_err = 0;
  int code_err = 0;
  logic prev_ev = 1'b0;
  logic scl_low_seen = 1'b0;
  logic sda_low_hi = 1'b0;
  int obs_code[$];
  int obs_cyc[$];
  int exp_code[$];
  int exp_cyc[$];
  vec_t tbl[4];

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_bitrecv #(.FILTER_CYCLES(F), .HOLD_CYCLES(H)) dut (
    .clk(clk),
    .reset(reset),
    .scl(scl_m),
    .sda(sda),
    .event_valid(event_valid),
    .event_code(event_code),
    .bus_busy(bus_busy),
    .drive_en(drive_en),
    .drive_bit(drive_bit),
    .drive_miss(drive_miss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (event_valid === 1'b1) begin
      obs_code.push_back(int'(event_code));
      obs_cyc.push_back(cyc);
      if (prev_ev) consec_err++;
    end
    if (event_valid === 1'b0 && event_code !== 3'd0) code_err++;
    prev_ev = (event_valid === 1'b1);
    if (drive_miss === 1'b1) begin
      miss_n++;
      miss_cyc = cyc;
    end
    if (dut.scl_f === 1'b0) scl_low_seen = 1'b1;
    if (sda === 1'b0 && scl_m) sda_low_hi = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int code);
    exp_code.push_back(code);
    exp_cyc.push_back(cyc + LAT);
  endtask

  task automatic check_events(input string name);
    int n;
    tick(20);
    chk({name, "_count"}, obs_code.size(), exp_code.size());
    n = (obs_code.size() < exp_code.size()) ? obs_code.size()
                                            : exp_code.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_code%0d", name, i), obs_code[i], exp_code[i]);
      chk($sformatf("%s_cyc%0d", name, i), obs_cyc[i], exp_cyc[i]);
    end
    obs_code.delete();
    obs_cyc.delete();
    exp_code.delete();
    exp_cyc.delete();
  endtask

  function automatic int bcode(input logic b);
    return b ? EV_BIT1 : EV_BIT0;
  endfunction

  task automatic do_start();
    sda_low = 1'b1;
    expect_ev(EV_START);
    tick(100);
    scl_m = 1'b0;
    last_fall = cyc;
  endtask

  task automatic bit_phase(input logic b, input int code, input logic arm,
                           input int tl, input int th, input int g);
    int ts;
    ts = tl / 4;
    tick(ts);
    sda_low = ~b;
    tick(tl - ts);
    scl_m = 1'b1;
    last_rise = cyc;
    tick(th / 2);
    drive_en = arm;
    drive_bit = 1'b0;
    if (g > 0) begin
      scl_m = 1'b0;
      tick(g);
      scl_m = 1'b1;
    end
    tick(th - th / 2);
    scl_m = 1'b0;
    last_fall = cyc;
    if (code != 0) expect_ev(code);
  endtask

  task automatic do_stop(input int tl);
    tick(tl / 4);
    sda_low = 1'b1;
    tick(tl - tl / 4);
    scl_m = 1'b1;
    tick(100);
    sda_low = 1'b0;
    expect_ev(EV_STOP);
    tick(100);
  endtask

  task automatic do_rstart();
    tick(50);
    sda_low = 1'b0;
    tick(150);
    scl_m = 1'b1;
    tick(100);
    sda_low = 1'b1;
    expect_ev(EV_START);
    tick(100);
    scl_m = 1'b0;
    last_fall = cyc;
  endtask

  initial begin
    logic [7:0] d;
    logic       b;
    int         p;
    int         nby;
    int         tl;
    int         th;

    tbl[0] = '{8'hA5, 8, 1'b0, 9'b1010_0101_0};
    tbl[1] = '{8'h00, 9, 1'b1, 9'b0000_0000_1};
    tbl[2] = '{8'hFF, 9, 1'b0, 9'b1111_1111_0};
    tbl[3] = '{8'h3C, 9, 1'b1, 9'b0011_1100_1};

    tick(4);
    chk("rst_valid", event_valid, 0);
    chk("rst_code", event_code, 0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_miss", drive_miss, 0);
    chk("rst_sda", sda, 1);
    reset = 1'b0;
    tick(20);
    obs_code.delete();
    obs_cyc.delete();

    // byte vectors, MSB first, with optional ninth (ACK) bit
    for (int v = 0; v < 4; v++) begin
      do_start();
      for (int i = 0; i < tbl[v].nbits; i++) begin
        b = (i < 8) ? tbl[v].data[7 - i] : tbl[v].ninth;
        bit_phase(b, tbl[v].exp_bits[8 - i] ? EV_BIT1 : EV_BIT0,
                  1'b0, 200, 200, 0);
      end
      chk($sformatf("vec%0d_busy", v), bus_busy, 1);
      do_stop(200);
      check_events($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_idle", v), bus_busy, 0);
      tick(30);
    end

    // target ACK with hold timing
    d = 8'h6B;
    do_start();
    for (int i = 0; i < 8; i++)
      bit_phase(d[7 - i], bcode(d[7 - i]), i == 7, 200, 200, 0);
    p = last_fall;
    tick(50);
    sda_low = 1'b0;
    tick(p + H + LAT - 1 - cyc);
    chk("ack_pre", sda, 1);
    tick(1);
    chk("ack_low", sda, 0);
    drive_en = 1'b0;
    tick(p + 200 - cyc);
    scl_m = 1'b1;
    tick(200);
    scl_m = 1'b0;
    expect_ev(EV_BIT0);
    p = cyc;
    tick(H + LAT - 1);
    chk("rel_pre", sda, 0);
    tick(1);
    chk("rel_high", sda, 1);
    tick(13);
    sda_low = 1'b1;
    tick(p + 200 - cyc);
    scl_m = 1'b1;
    tick(100);
    sda_low = 1'b0;
    expect_ev(EV_STOP);
    tick(100);
    check_events("ack");
    tick(30);

    // sub-filter glitches, then accepted 4-cycle pulses
    scl_low_seen = 1'b0;
    scl_m = 1'b0;
    tick(F - 1);
    scl_m = 1'b1;
    tick(20);
    chk("glitch_scl", scl_low_seen, 0);
    sda_low = 1'b1;
    tick(F - 1);
    sda_low = 1'b0;
    tick(20);
    check_events("glitch_sda");
    sda_low = 1'b1;
    expect_ev(EV_START);
    tick(F);
    sda_low = 1'b0;
    expect_ev(EV_STOP);
    check_events("pulse_sda");
    scl_m = 1'b0;
    tick(F);
    scl_m = 1'b1;
    tick(20);
    chk("pulse_scl", scl_low_seen, 1);
    check_events("pulse_scl_ev");
    tick(30);

    // repeated START in the middle of a bit
    do_start();
    bit_phase(1'b1, EV_BIT1, 1'b0, 200, 200, 0);
    bit_phase(1'b0, EV_BIT0, 1'b0, 200, 200, 0);
    do_rstart();
    chk("rs_busy", bus_busy, 1);
    bit_phase(1'b0, EV_BIT0, 1'b0, 200, 200, 0);
    bit_phase(1'b1, EV_BIT1, 1'b0, 200, 200, 0);
    chk("rs_busy2", bus_busy, 1);
    do_stop(200);
    check_events("rstart");
    tick(30);

    // short SCL low phase abandons a pending drive
    miss_n = 0;
    drive_en = 1'b1;
    drive_bit = 1'b0;
    do_start();
    sda_low_hi = 1'b0;
    bit_phase(1'b1, EV_BIT1, 1'b0, 50, 200, 0);
    chk("miss_count", miss_n, 1);
    chk("miss_cyc", miss_cyc, last_rise + LAT);
    chk("miss_oe_hold", sda_low_hi, 0);
    do_stop(200);
    chk("miss_total", miss_n, 1);
    check_events("miss");
    tick(30);

    // reset while the target holds SDA low
    do_start();
    bit_phase(1'b1, EV_BIT1, 1'b0, 200, 200, 0);
    bit_phase(1'b0, EV_BIT0, 1'b0, 200, 200, 0);
    bit_phase(1'b1, EV_BIT1, 1'b1, 200, 200, 0);
    p = last_fall;
    tick(50);
    sda_low = 1'b0;
    tick(99);
    chk("rst_drv_low", sda, 0);
    reset = 1'b1;
    tick(1);
    chk("mrst_sda", sda, 1);
    chk("mrst_valid", event_valid, 0);
    chk("mrst_busy", bus_busy, 0);
    chk("mrst_miss", drive_miss, 0);
    reset = 1'b0;
    drive_en = 1'b0;
    tick(p + 200 - cyc);
    scl_m = 1'b1;
    tick(200);
    scl_m = 1'b0;
    bit_phase(1'b0, 0, 1'b0, 200, 200, 0);
    bit_phase(1'b1, 0, 1'b0, 200, 200, 0);
    chk("mrst_idle", bus_busy, 0);
    do_stop(200);
    check_events("midreset");
    tick(30);

    // random transactions with SCL glitches in the high phase
    for (int t = 0; t < 4; t++) begin
      nby = $urandom_range(1, 2);
      tl = $urandom_range(120, 200);
      th = $urandom_range(120, 200);
      do_start();
      for (int k = 0; k < nby; k++) begin
        d = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
          b = (i < 8) ? d[7 - i] : 1'($urandom);
          bit_phase(b, bcode(b), 1'b0, tl, th, $urandom_range(0, F - 1));
        end
        if (k + 1 < nby && $urandom_range(0, 1) == 1) do_rstart();
      end
      do_stop(tl);
      check_events($sformatf("rand%0d", t));
      tick(30);
    end

    chk("no_back_to_back", consec_err, 0);
    chk("code_zero_idle", code_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
